// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared widths, rw encoding and FSM states for the memory bus master
package mem_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        REQ,
        RELEASE,
        DONE
    } state_t;

endpackage

// File: rtl/mem_bus_timer.sv
// rtl/mem_bus_timer.sv - clearable saturating wait counter with a timeout strobe
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   clear       zero the count on the next edge (phase entry or an edge that ends the wait)
//   tick        this cycle is another cycle without the expected wait_ level
//   expired     this tick is the TIMEOUT_CYCLES-th consecutive one; never set when TIMEOUT_CYCLES=0
module mem_bus_timer #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    // Fires combinationally so the FSM leaves the phase on the edge that completes
    // the TIMEOUT_CYCLES-th miss rather than one cycle later.
    assign expired = (TIMEOUT_CYCLES != 0) && tick && (count == LIMIT - 1'b1);

endmodule

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - single-word CPU to memory bus initiator (setup/request/ack/release)
// Ports:
//   clk, reset                      clock and asynchronous active-high reset
//   cpu_start/cpu_rw/cpu_addr/cpu_wdata  command from the CPU, taken only while cpu_ready
//   cpu_ready/cpu_done/cpu_error    idle flag, completion pulse, timeout pulse
//   cpu_rdata                       last successfully read word
//   addrs_bus/request/rw/data_bus_write  registered bus drive toward the memory
//   wait_/data_bus_read             responder ack (active low) and read data
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_start,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic              cpu_error,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] addrs_bus,
    output logic              request,
    output logic              rw,
    output logic [DATA_W-1:0] data_bus_write,
    input  logic              wait_,
    input  logic [DATA_W-1:0] data_bus_read
);

    state_t state;
    logic   err_flag;
    logic   tick;
    logic   clear;
    logic   expired;

    // A miss is a cycle in REQ still seeing wait_=1, or in RELEASE still seeing wait_=0.
    // Any hit ends the phase, and a timeout ends it too, so both restart the count.
    assign tick  = ((state == REQ) && wait_) || ((state == RELEASE) && !wait_);
    assign clear = !tick || expired;

    mem_bus_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .tick   (tick),
        .expired(expired)
    );

    assign cpu_ready = (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            request        <= 1'b0;
            rw             <= RW_READ;
            addrs_bus      <= '0;
            data_bus_write <= '0;
            cpu_rdata      <= '0;
            cpu_done       <= 1'b0;
            cpu_error      <= 1'b0;
            err_flag       <= 1'b0;
        end else begin
            cpu_done  <= 1'b0;
            cpu_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_start) begin
                        addrs_bus      <= cpu_addr;
                        rw             <= cpu_rw;
                        data_bus_write <= cpu_wdata;
                        err_flag       <= 1'b0;
                        state          <= SETUP;
                    end
                end
                SETUP: begin
                    request <= 1'b1;
                    state   <= REQ;
                end
                REQ: begin
                    if (!wait_) begin
                        if (rw == RW_READ) begin
                            cpu_rdata <= data_bus_read;
                        end
                        request <= 1'b0;
                        state   <= RELEASE;
                    end else if (expired) begin
                        err_flag <= 1'b1;
                        request  <= 1'b0;
                        state    <= RELEASE;
                    end
                end
                RELEASE: begin
                    // expired here implies wait_ is still low: the responder never let go.
                    if (wait_ || expired) begin
                        cpu_done  <= 1'b1;
                        cpu_error <= err_flag || expired;
                        rw        <= RW_READ;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
